// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants: instruction width, canonical NOP encoding and fetch fault codes.
package legv8_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] LEGV8_NOP = 32'hD503201F;

    localparam logic [1:0] FETCH_OK       = 2'b00;
    localparam logic [1:0] FETCH_MISALIGN = 2'b01;
    localparam logic [1:0] FETCH_RANGE    = 2'b10;
endpackage

// File: rtl/imem_array.sv
// Instruction RAM: single write port, registered read port; the read register is the response data stage.
// Latency 1 cycle on read; rd_data holds its value whenever rd_en is low.
module imem_array
    import legv8_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [INST_W-1:0] rd_data
);

    logic [INST_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= LEGV8_NOP;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch port: valid/ready PC request, one-cycle registered response with fault decode.
// Response held while resp_valid && !resp_ready; program loads block requests.
module imem_fetch
    import legv8_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PC_W  = 64,
    parameter int CNT_W = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PC_W-1:0]   req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [INST_W-1:0] resp_inst,
    output logic [PC_W-1:0]   resp_pc,
    output logic [1:0]        resp_fault,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [INST_W-1:0] ld_data,
    output logic [CNT_W-1:0]  fetch_cnt
);

    logic              accept;
    logic              misalign;
    logic              out_of_range;
    logic [1:0]        fault_d;
    logic [INST_W-1:0] rd_data;

    assign req_ready = !reset && !ld_en && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready && !flush;

    // Upper PC bits are checked rather than dropped so high PCs never alias into the array.
    assign misalign     = (req_pc[1:0] != 2'b00);
    assign out_of_range = (req_pc[PC_W-1:AW+2] != '0);

    always_comb begin
        fault_d = FETCH_OK;
        if (misalign) begin
            fault_d = FETCH_MISALIGN;
        end else if (out_of_range) begin
            fault_d = FETCH_RANGE;
        end
    end

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (accept),
        .rd_addr (req_pc[AW+1:2]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_pc    <= '0;
            resp_fault <= FETCH_OK;
        end else begin
            if (flush) begin
                resp_valid <= 1'b0;
            end else if (accept) begin
                resp_valid <= 1'b1;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (accept) begin
                resp_pc    <= req_pc;
                resp_fault <= fault_d;
            end
        end
    end

    assign resp_inst = (resp_fault == FETCH_OK) ? rd_data : LEGV8_NOP;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
        end else if (accept && (fault_d == FETCH_OK) && (fetch_cnt != {CNT_W{1'b1}})) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: per-cycle vector table plus a hand-written stream/back-pressure sequence.
module tb_imem_fetch;

    localparam int DEPTH = 64;
    localparam int PC_W  = 64;
    localparam int CNT_W = 3;
    localparam int AW    = 6;

    localparam logic [31:0] NOP = 32'hD503201F;
    localparam logic [31:0] W0  = 32'h9101BFE1;
    localparam logic [31:0] W1  = 32'h91005BE2;
    localparam logic [31:0] W2  = 32'h910087E3;
    localparam logic [31:0] W3  = 32'h91013BE4;
    localparam logic [31:0] W5  = 32'h8B010002;
    localparam logic [31:0] W63 = 32'h12345678;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [PC_W-1:0]   req_pc;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_inst;
    logic [PC_W-1:0]   resp_pc;
    logic [1:0]        resp_fault;
    logic              flush;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [31:0]       ld_data;
    logic [CNT_W-1:0]  fetch_cnt;

    always #5 clk = ~clk;

    imem_fetch #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_pc    (resp_pc),
        .resp_fault (resp_fault),
        .flush      (flush),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .fetch_cnt  (fetch_cnt)
    );

    typedef struct {
        logic             rst;
        logic             rv;
        logic [PC_W-1:0]  pc;
        logic             rr;
        logic             fl;
        logic             ld;
        logic [AW-1:0]    la;
        logic [31:0]      ldat;
        logic             e_rdy;
        logic             e_v;
        logic [31:0]      e_inst;
        logic [PC_W-1:0]  e_pc;
        logic [1:0]       e_flt;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cur    = 0;

    function automatic vec_t mk(logic rst, logic rv, logic [PC_W-1:0] pc, logic rr, logic fl,
                                logic ld, logic [AW-1:0] la, logic [31:0] ldat,
                                logic e_rdy, logic e_v, logic [31:0] e_inst,
                                logic [PC_W-1:0] e_pc, logic [1:0] e_flt, logic [CNT_W-1:0] e_cnt);
        vec_t v;
        v.rst = rst; v.rv = rv; v.pc = pc; v.rr = rr; v.fl = fl;
        v.ld = ld; v.la = la; v.ldat = ldat;
        v.e_rdy = e_rdy; v.e_v = e_v; v.e_inst = e_inst;
        v.e_pc = e_pc; v.e_flt = e_flt; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [PC_W-1:0] pc,
                         input logic rr, input logic fl, input logic ld,
                         input logic [AW-1:0] la, input logic [31:0] ldat);
        reset = rst; req_valid = rv; req_pc = pc; resp_ready = rr;
        flush = fl; ld_en = ld; ld_addr = la; ld_data = ldat;
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Reset, program load, reset again
        vecs.push_back(mk(1,0,64'd0,1,0,0,6'd0,32'd0,  0,0,NOP,64'd0,2'd0,3'd0));
        vecs.push_back(mk(0,0,64'd0,1,0,1,6'd0,W0,     0,0,NOP,64'd0,2'd0,3'd0));
        vecs.push_back(mk(0,0,64'd0,1,0,1,6'd1,W1,     0,0,NOP,64'd0,2'd0,3'd0));
        vecs.push_back(mk(0,0,64'd0,1,0,1,6'd2,W2,     0,0,NOP,64'd0,2'd0,3'd0));
        vecs.push_back(mk(0,0,64'd0,1,0,1,6'd3,W3,     0,0,NOP,64'd0,2'd0,3'd0));
        vecs.push_back(mk(0,0,64'd0,1,0,1,6'd63,W63,   0,0,NOP,64'd0,2'd0,3'd0));
        vecs.push_back(mk(1,0,64'd0,1,0,0,6'd0,32'd0,  0,0,NOP,64'd0,2'd0,3'd0));
        // Back-to-back stream
        vecs.push_back(mk(0,1,64'd0,1,0,0,6'd0,32'd0,  1,1,W0,64'd0,2'd0,3'd1));
        vecs.push_back(mk(0,1,64'd4,1,0,0,6'd0,32'd0,  1,1,W1,64'd4,2'd0,3'd2));
        vecs.push_back(mk(0,1,64'd8,1,0,0,6'd0,32'd0,  1,1,W2,64'd8,2'd0,3'd3));
        vecs.push_back(mk(0,1,64'd12,1,0,0,6'd0,32'd0, 1,1,W3,64'd12,2'd0,3'd4));
        vecs.push_back(mk(0,0,64'd0,1,0,0,6'd0,32'd0,  1,0,NOP,64'd0,2'd0,3'd4));
        // Back-pressure: PC 4 response held three cycles while PC 8 waits
        vecs.push_back(mk(0,1,64'd4,1,0,0,6'd0,32'd0,  1,1,W1,64'd4,2'd0,3'd5));
        vecs.push_back(mk(0,1,64'd8,0,0,0,6'd0,32'd0,  0,1,W1,64'd4,2'd0,3'd5));
        vecs.push_back(mk(0,1,64'd8,0,0,0,6'd0,32'd0,  0,1,W1,64'd4,2'd0,3'd5));
        vecs.push_back(mk(0,1,64'd8,0,0,0,6'd0,32'd0,  0,1,W1,64'd4,2'd0,3'd5));
        vecs.push_back(mk(0,1,64'd8,1,0,0,6'd0,32'd0,  1,1,W2,64'd8,2'd0,3'd6));
        vecs.push_back(mk(0,0,64'd0,1,0,0,6'd0,32'd0,  1,0,NOP,64'd0,2'd0,3'd6));
        // Faults, including a high PC that would alias onto word 0 if truncated
        vecs.push_back(mk(0,1,64'd6,1,0,0,6'd0,32'd0,  1,1,NOP,64'd6,2'd1,3'd6));
        vecs.push_back(mk(0,1,64'd256,1,0,0,6'd0,32'd0,1,1,NOP,64'd256,2'd2,3'd6));
        vecs.push_back(mk(0,1,64'd258,1,0,0,6'd0,32'd0,1,1,NOP,64'd258,2'd1,3'd6));
        vecs.push_back(mk(0,1,64'h1_0000_0000,1,0,0,6'd0,32'd0, 1,1,NOP,64'h1_0000_0000,2'd2,3'd6));
        // Last in-range word; counter reaches its 3-bit maximum
        vecs.push_back(mk(0,1,64'd252,1,0,0,6'd0,32'd0,1,1,W63,64'd252,2'd0,3'd7));
        vecs.push_back(mk(0,0,64'd0,1,0,0,6'd0,32'd0,  1,0,NOP,64'd0,2'd0,3'd7));
        // Saturation, then flush of a held response with a same-cycle PC 12 request
        vecs.push_back(mk(0,1,64'd0,0,0,0,6'd0,32'd0,  1,1,W0,64'd0,2'd0,3'd7));
        vecs.push_back(mk(0,0,64'd0,0,0,0,6'd0,32'd0,  0,1,W0,64'd0,2'd0,3'd7));
        vecs.push_back(mk(0,1,64'd12,1,1,0,6'd0,32'd0, 1,0,NOP,64'd0,2'd0,3'd7));
        vecs.push_back(mk(0,0,64'd0,1,0,0,6'd0,32'd0,  1,0,NOP,64'd0,2'd0,3'd7));
        // Load priority over a pending request
        vecs.push_back(mk(0,1,64'd20,1,0,1,6'd5,W5,    0,0,NOP,64'd0,2'd0,3'd7));
        vecs.push_back(mk(0,1,64'd20,1,0,0,6'd0,32'd0, 1,1,W5,64'd20,2'd0,3'd7));
        // Reset while a response is held; memory must survive
        vecs.push_back(mk(0,1,64'd252,1,0,0,6'd0,32'd0,1,1,W63,64'd252,2'd0,3'd7));
        vecs.push_back(mk(0,0,64'd0,0,0,0,6'd0,32'd0,  0,1,W63,64'd252,2'd0,3'd7));
        vecs.push_back(mk(1,1,64'd0,0,0,0,6'd0,32'd0,  0,0,NOP,64'd0,2'd0,3'd0));
        vecs.push_back(mk(0,1,64'd0,1,0,0,6'd0,32'd0,  1,1,W0,64'd0,2'd0,3'd1));
        vecs.push_back(mk(0,0,64'd0,1,0,0,6'd0,32'd0,  1,0,NOP,64'd0,2'd0,3'd1));

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            drive(vecs[i].rst, vecs[i].rv, vecs[i].pc, vecs[i].rr, vecs[i].fl,
                  vecs[i].ld, vecs[i].la, vecs[i].ldat);
            #2;
            check("req_ready", 64'(req_ready), 64'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            check("resp_valid", 64'(resp_valid), 64'(vecs[i].e_v));
            check("fetch_cnt", 64'(fetch_cnt), 64'(vecs[i].e_cnt));
            if (vecs[i].e_v || vecs[i].rst) begin
                check("resp_inst", 64'(resp_inst), 64'(vecs[i].e_inst));
                check("resp_pc", resp_pc, vecs[i].e_pc);
                check("resp_fault", 64'(resp_fault), 64'(vecs[i].e_flt));
            end
        end

        // Full-rate stream of words 0..3, then a held PC 12 response with PC 0 pending
        begin
            logic [31:0] words [4];
            words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
            for (int k = 0; k < 4; k++) begin
                cur = 100 + k;
                drive(1'b0, 1'b1, PC_W'(4 * k), 1'b1, 1'b0, 1'b0, '0, '0);
                @(posedge clk);
                #1;
                check("stream_inst", 64'(resp_inst), 64'(words[k]));
                check("stream_pc", resp_pc, 64'(4 * k));
                check("stream_cnt", 64'(fetch_cnt), 64'(k + 2));
            end
            cur = 110;
            drive(1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0, '0, '0);
            #1;
            check("hold_ready", 64'(req_ready), 64'd0);
            for (int k = 0; k < 3; k++) begin
                cur = 111 + k;
                @(posedge clk);
                #1;
                check("hold_inst", 64'(resp_inst), 64'(W3));
                check("hold_pc", resp_pc, 64'd12);
            end
            cur = 120;
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            check("release_inst", 64'(resp_inst), 64'(W0));
            check("release_pc", resp_pc, 64'd0);
            check("release_cnt", 64'(fetch_cnt), 64'd6);
            req_valid = 1'b0;
            @(posedge clk);
            #1;
            check("drain_valid", 64'(resp_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
